// File: rtl/ctrl_pipe_pkg.sv
// Shared RV32I field positions, opcode/funct encodings, control enums and the
// decoded control bundle used by ctrl_dec and ctrl_pipe.
package ctrl_pipe_pkg;

   localparam int INST_WIDTH       = 32;
   localparam int REG_ADDR_W       = 5;
   localparam int IMM_GEN_OP_WIDTH = 3;
   localparam int ALU_OP_WIDTH     = 4;
   localparam int ALU_SRC_WIDTH    = 2;

   localparam int OPCODE_BASE = 0;
   localparam int RD_BASE     = 7;
   localparam int FUNCT3_BASE = 12;
   localparam int RS1_BASE    = 15;
   localparam int RS2_BASE    = 20;
   localparam int FUNCT7_BASE = 25;

   localparam logic [6:0] INST_R      = 7'b0110011;
   localparam logic [6:0] INST_I      = 7'b0010011;
   localparam logic [6:0] INST_LOAD   = 7'b0000011;
   localparam logic [6:0] INST_STORE  = 7'b0100011;
   localparam logic [6:0] INST_BRANCH = 7'b1100011;
   localparam logic [6:0] INST_JAL    = 7'b1101111;
   localparam logic [6:0] INST_JALR   = 7'b1100111;
   localparam logic [6:0] INST_LUI    = 7'b0110111;
   localparam logic [6:0] INST_AUIPC  = 7'b0010111;

   localparam logic [6:0] FUNCT7_STD = 7'b0000000;
   localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

   localparam logic [2:0] FUNCT3_ADD  = 3'b000;
   localparam logic [2:0] FUNCT3_SLL  = 3'b001;
   localparam logic [2:0] FUNCT3_SLT  = 3'b010;
   localparam logic [2:0] FUNCT3_SLTU = 3'b011;
   localparam logic [2:0] FUNCT3_XOR  = 3'b100;
   localparam logic [2:0] FUNCT3_SR   = 3'b101;
   localparam logic [2:0] FUNCT3_OR   = 3'b110;
   localparam logic [2:0] FUNCT3_AND  = 3'b111;
   localparam logic [2:0] FUNCT3_LW   = 3'b010;
   localparam logic [2:0] FUNCT3_SW   = 3'b010;
   localparam logic [2:0] FUNCT3_JALR = 3'b000;

   typedef enum logic [IMM_GEN_OP_WIDTH-1:0] {
      IMM_GEN_I = 3'd0,
      IMM_GEN_S = 3'd1,
      IMM_GEN_B = 3'd2,
      IMM_GEN_U = 3'd3,
      IMM_GEN_J = 3'd4
   } imm_gen_e;

   typedef enum logic [ALU_OP_WIDTH-1:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_op_e;

   typedef enum logic [ALU_SRC_WIDTH-1:0] {
      ALU_SRC_REG     = 2'd0,
      ALU_SRC_IMM     = 2'd1,
      ALU_SRC_FOUR_PC = 2'd2,
      ALU_SRC_PC_IMM  = 2'd3
   } alu_src_e;

   typedef struct packed {
      logic                  branch;
      logic                  jump;
      logic                  jalr;
      logic                  mem_ren;
      logic                  mem_wen;
      logic                  reg_wen;
      logic [REG_ADDR_W-1:0] reg_waddr;
      logic [REG_ADDR_W-1:0] reg1_raddr;
      logic [REG_ADDR_W-1:0] reg2_raddr;
      imm_gen_e              imm_gen_op;
      alu_op_e               alu_op;
      alu_src_e              alu_src_sel;
      logic                  illegal;
   } ctrl_bundle_t;

   localparam int BUNDLE_WIDTH = $bits(ctrl_bundle_t);

   localparam ctrl_bundle_t BUNDLE_RST = '{
      branch:      1'b0,
      jump:        1'b0,
      jalr:        1'b0,
      mem_ren:     1'b0,
      mem_wen:     1'b0,
      reg_wen:     1'b0,
      reg_waddr:   '0,
      reg1_raddr:  '0,
      reg2_raddr:  '0,
      imm_gen_op:  IMM_GEN_I,
      alu_op:      ALU_AND,
      alu_src_sel: ALU_SRC_REG,
      illegal:     1'b0
   };

   // alt selects SUB/SRA; callers decide when funct7[5] is meaningful.
   function automatic alu_op_e alu_arith(input logic [2:0] funct3, input logic alt);
      alu_op_e op;
      op = ALU_AND;
      case (funct3)
         FUNCT3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
         FUNCT3_SLL:  op = ALU_SLL;
         FUNCT3_SLT:  op = ALU_SLT;
         FUNCT3_SLTU: op = ALU_SLTU;
         FUNCT3_XOR:  op = ALU_XOR;
         FUNCT3_SR:   op = alt ? ALU_SRA : ALU_SRL;
         FUNCT3_OR:   op = ALU_OR;
         FUNCT3_AND:  op = ALU_AND;
         default:     op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// Fetch-side and execute-side handshake plus decoded control bundle of ctrl_pipe.
// slave is the decoder pipe's view, master is the surrounding pipeline's view.
interface ctrl_pipe_if #(
   parameter int CPU_WIDTH      = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int PC_WIDTH       = 32
) ();
   import ctrl_pipe_pkg::*;

   logic                        flush;
   logic                        in_valid;
   logic                        in_ready;
   logic [CPU_WIDTH-1:0]        in_inst;
   logic [PC_WIDTH-1:0]         in_pc;

   logic                        out_valid;
   logic                        out_ready;
   logic [PC_WIDTH-1:0]         out_pc;
   logic [CPU_WIDTH-1:0]        out_inst;
   logic                        branch;
   logic                        jump;
   logic                        jalr;
   logic                        mem_ren;
   logic                        mem_wen;
   logic                        reg_wen;
   logic [REG_ADDR_WIDTH-1:0]   reg_waddr;
   logic [REG_ADDR_WIDTH-1:0]   reg1_raddr;
   logic [REG_ADDR_WIDTH-1:0]   reg2_raddr;
   logic [IMM_GEN_OP_WIDTH-1:0] imm_gen_op;
   logic [ALU_OP_WIDTH-1:0]     alu_op;
   logic [ALU_SRC_WIDTH-1:0]    alu_src_sel;
   logic                        illegal;

   modport slave (
      input  flush, in_valid, in_inst, in_pc, out_ready,
      output in_ready, out_valid, out_pc, out_inst,
             branch, jump, jalr, mem_ren, mem_wen, reg_wen,
             reg_waddr, reg1_raddr, reg2_raddr,
             imm_gen_op, alu_op, alu_src_sel, illegal
   );

   modport master (
      output flush, in_valid, in_inst, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, out_inst,
             branch, jump, jalr, mem_ren, mem_wen, reg_wen,
             reg_waddr, reg1_raddr, reg2_raddr,
             imm_gen_op, alu_op, alu_src_sel, illegal
   );

endinterface

// File: rtl/ctrl_pipe_dec.sv
// ctrl_dec: combinational RV32I control decoder (instruction word -> control bundle).
// Define CTRL_RVE_EN to flag any used register above x15 as illegal.
module ctrl_dec
   import ctrl_pipe_pkg::*;
(
   input  logic [INST_WIDTH-1:0] inst,
   output ctrl_bundle_t          bundle
);

   logic [6:0]            opcode;
   logic [2:0]            funct3;
   logic [6:0]            funct7;
   logic [REG_ADDR_W-1:0] rd;
   logic [REG_ADDR_W-1:0] rs1;
   logic [REG_ADDR_W-1:0] rs2;

   assign opcode = inst[OPCODE_BASE +: 7];
   assign funct3 = inst[FUNCT3_BASE +: 3];
   assign funct7 = inst[FUNCT7_BASE +: 7];
   assign rd     = inst[RD_BASE +: REG_ADDR_W];
   assign rs1    = inst[RS1_BASE +: REG_ADDR_W];
   assign rs2    = inst[RS2_BASE +: REG_ADDR_W];

   logic use_rd;
   logic use_rs1;
   logic use_rs2;
   logic bad;
   logic rve_bad;
   logic r_ok;
   logic i_ok;

   always_comb begin
      bundle  = BUNDLE_RST;
      use_rd  = 1'b0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      bad     = 1'b0;
      rve_bad = 1'b0;

      r_ok = (funct7 == FUNCT7_STD) ||
             ((funct7 == FUNCT7_ALT) && ((funct3 == FUNCT3_ADD) || (funct3 == FUNCT3_SR)));

      // Shift-immediates reuse funct7 as an encoding field; other I-ops carry imm bits there.
      case (funct3)
         FUNCT3_SLL: i_ok = (funct7 == FUNCT7_STD);
         FUNCT3_SR:  i_ok = (funct7 == FUNCT7_STD) || (funct7 == FUNCT7_ALT);
         default:    i_ok = 1'b1;
      endcase

      case (opcode)
         INST_R: begin
            use_rd  = 1'b1;
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            bundle.alu_op = alu_arith(funct3, funct7[5]);
            bad = !r_ok;
         end
         INST_I: begin
            use_rd  = 1'b1;
            use_rs1 = 1'b1;
            bundle.imm_gen_op  = IMM_GEN_I;
            bundle.alu_op      = alu_arith(funct3, (funct3 == FUNCT3_SR) && funct7[5]);
            bundle.alu_src_sel = ALU_SRC_IMM;
            bad = !i_ok;
         end
         INST_LOAD: begin
            use_rd  = 1'b1;
            use_rs1 = 1'b1;
            bundle.mem_ren     = 1'b1;
            bundle.imm_gen_op  = IMM_GEN_I;
            bundle.alu_op      = ALU_ADD;
            bundle.alu_src_sel = ALU_SRC_IMM;
            bad = (funct3 != FUNCT3_LW);
         end
         INST_STORE: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            bundle.mem_wen     = 1'b1;
            bundle.imm_gen_op  = IMM_GEN_S;
            bundle.alu_op      = ALU_ADD;
            bundle.alu_src_sel = ALU_SRC_IMM;
            bad = (funct3 != FUNCT3_SW);
         end
         INST_BRANCH: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            bundle.branch     = 1'b1;
            bundle.imm_gen_op = IMM_GEN_B;
            // funct3[0] only inverts the sense; the pair picks the comparison.
            case (funct3[2:1])
               2'b00:   bundle.alu_op = ALU_SUB;
               2'b10:   bundle.alu_op = ALU_SLT;
               2'b11:   bundle.alu_op = ALU_SLTU;
               default: bad = 1'b1;
            endcase
         end
         INST_JAL: begin
            use_rd = 1'b1;
            bundle.jump        = 1'b1;
            bundle.imm_gen_op  = IMM_GEN_J;
            bundle.alu_op      = ALU_ADD;
            bundle.alu_src_sel = ALU_SRC_FOUR_PC;
         end
         INST_JALR: begin
            use_rd  = 1'b1;
            use_rs1 = 1'b1;
            bundle.jump        = 1'b1;
            bundle.jalr        = 1'b1;
            bundle.imm_gen_op  = IMM_GEN_I;
            bundle.alu_op      = ALU_ADD;
            bundle.alu_src_sel = ALU_SRC_FOUR_PC;
            bad = (funct3 != FUNCT3_JALR);
         end
         INST_LUI: begin
            use_rd = 1'b1;
            bundle.imm_gen_op  = IMM_GEN_U;
            bundle.alu_op      = ALU_ADD;
            bundle.alu_src_sel = ALU_SRC_IMM;
         end
         INST_AUIPC: begin
            use_rd = 1'b1;
            bundle.imm_gen_op  = IMM_GEN_U;
            bundle.alu_op      = ALU_ADD;
            bundle.alu_src_sel = ALU_SRC_PC_IMM;
         end
         default: bad = 1'b1;
      endcase

`ifdef CTRL_RVE_EN
      rve_bad = (use_rd && rd[4]) || (use_rs1 && rs1[4]) || (use_rs2 && rs2[4]);
`else
      rve_bad = 1'b0;
`endif

      bundle.reg_waddr  = use_rd  ? rd  : '0;
      bundle.reg1_raddr = use_rs1 ? rs1 : '0;
      bundle.reg2_raddr = use_rs2 ? rs2 : '0;
      bundle.reg_wen    = use_rd && (rd != '0);
      bundle.illegal    = bad || rve_bad;

      // Illegal bundles still travel downstream but must have no side effects.
      if (bundle.illegal) begin
         bundle.branch  = 1'b0;
         bundle.jump    = 1'b0;
         bundle.jalr    = 1'b0;
         bundle.mem_ren = 1'b0;
         bundle.mem_wen = 1'b0;
         bundle.reg_wen = 1'b0;
      end
   end

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: registered RV32I control decode stage between IF and EX with a
// two-entry skid buffer and flush. CTRL_RVE_EN selects the RV32E register check.
//
// state    | meaning
// ST_EMPTY | no decoded bundle held, out_valid=0
// ST_ONE   | main register valid, skid register empty
// ST_TWO   | main and skid registers valid, in_ready=0
module ctrl_pipe
   import ctrl_pipe_pkg::*;
#(
   parameter int CPU_WIDTH      = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int PC_WIDTH       = 32
) (
   input  logic       clk,
   input  logic       rst,
   ctrl_pipe_if.slave bus
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } skid_state_e;

   skid_state_e          state_q;
   skid_state_e          state_nxt;
   logic                 in_ready_q;
   logic                 accept;
   logic                 pop;
   logic                 load_main_in;
   logic                 load_main_skid;
   logic                 load_skid;

   ctrl_bundle_t         dec_bundle;
   ctrl_bundle_t         main_bundle_q;
   ctrl_bundle_t         skid_bundle_q;
   logic [PC_WIDTH-1:0]  main_pc_q;
   logic [PC_WIDTH-1:0]  skid_pc_q;
   logic [CPU_WIDTH-1:0] main_inst_q;
   logic [CPU_WIDTH-1:0] skid_inst_q;

   ctrl_dec u_dec (
      .inst   (bus.in_inst[INST_WIDTH-1:0]),
      .bundle (dec_bundle)
   );

   // An instruction offered alongside flush belongs to the squashed path.
   assign accept = bus.in_valid && in_ready_q && !bus.flush;
   assign pop    = (state_q != ST_EMPTY) && bus.out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_nxt;
      end
   end

   always_comb begin
      state_nxt      = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (bus.flush) begin
         state_nxt = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  state_nxt    = ST_ONE;
                  load_main_in = 1'b1;
               end
            end
            ST_ONE: begin
               if (pop && accept) begin
                  load_main_in = 1'b1;
               end else if (pop) begin
                  state_nxt = ST_EMPTY;
               end else if (accept) begin
                  state_nxt = ST_TWO;
                  load_skid = 1'b1;
               end
            end
            ST_TWO: begin
               if (pop) begin
                  state_nxt      = ST_ONE;
                  load_main_skid = 1'b1;
               end
            end
            default: state_nxt = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_ready_q    <= 1'b0;
         main_bundle_q <= BUNDLE_RST;
         main_pc_q     <= '0;
         main_inst_q   <= '0;
         skid_bundle_q <= BUNDLE_RST;
         skid_pc_q     <= '0;
         skid_inst_q   <= '0;
      end else begin
         // Ready looks ahead at the next occupancy so no combinational path from out_ready.
         in_ready_q <= (state_nxt != ST_TWO);
         if (load_main_in) begin
            main_bundle_q <= dec_bundle;
            main_pc_q     <= bus.in_pc;
            main_inst_q   <= bus.in_inst;
         end else if (load_main_skid) begin
            main_bundle_q <= skid_bundle_q;
            main_pc_q     <= skid_pc_q;
            main_inst_q   <= skid_inst_q;
         end
         if (load_skid) begin
            skid_bundle_q <= dec_bundle;
            skid_pc_q     <= bus.in_pc;
            skid_inst_q   <= bus.in_inst;
         end
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = (state_q != ST_EMPTY);
   assign bus.out_pc      = main_pc_q;
   assign bus.out_inst    = main_inst_q;
   assign bus.branch      = main_bundle_q.branch;
   assign bus.jump        = main_bundle_q.jump;
   assign bus.jalr        = main_bundle_q.jalr;
   assign bus.mem_ren     = main_bundle_q.mem_ren;
   assign bus.mem_wen     = main_bundle_q.mem_wen;
   assign bus.reg_wen     = main_bundle_q.reg_wen;
   assign bus.reg_waddr   = REG_ADDR_WIDTH'(main_bundle_q.reg_waddr);
   assign bus.reg1_raddr  = REG_ADDR_WIDTH'(main_bundle_q.reg1_raddr);
   assign bus.reg2_raddr  = REG_ADDR_WIDTH'(main_bundle_q.reg2_raddr);
   assign bus.imm_gen_op  = main_bundle_q.imm_gen_op;
   assign bus.alu_op      = main_bundle_q.alu_op;
   assign bus.alu_src_sel = main_bundle_q.alu_src_sel;
   assign bus.illegal     = main_bundle_q.illegal;

endmodule
